// File: rtl/multiword_adder_ctrl_if.sv
// Operand/result bundle for the multi-word add/subtract sequencer.
// The master side issues operations; the slave side is the sequencer.
interface multiword_adder_ctrl_if #(
  parameter int NUM_WORDS = 4
);
  localparam int W = 16 * NUM_WORDS;

  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         busy;
  logic         done;

  modport master (
    output start, sub, cin, a, b,
    input  sum, cout, overflow, busy, done
  );

  modport slave (
    input  start, sub, cin, a, b,
    output sum, cout, overflow, busy, done
  );
endinterface

// File: rtl/multiword_adder_ctrl.sv
// Wide add/subtract built from one 16-bit slice reused once per word,
// least-significant word first, with the carry held in a register.
module multiword_adder_ctrl #(
  parameter int NUM_WORDS = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  multiword_adder_ctrl_if.slave bus
);
  localparam int W     = 16 * NUM_WORDS;
  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [W-1:0]     a_sh_r;
  logic [W-1:0]     b_sh_r;
  logic [W-1:0]     res_sh_r;
  logic             carry_r;
  logic [IDX_W-1:0] idx_r;
  logic [W-1:0]     sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             busy_r;
  logic             done_r;

  logic [16:0]      slice_s;
  logic [W-1:0]     res_next_s;

  // Shared 16-bit slice and the result word shifted in from the top
  always_comb begin
    slice_s    = {1'b0, a_sh_r[15:0]} + {1'b0, b_sh_r[15:0]} + {16'h0000, carry_r};
    res_next_s = {slice_s[15:0], res_sh_r[W-1:16]};
  end

  // Sequencer: capture on start, one word per edge, publish on the last word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      a_sh_r   <= '0;
      b_sh_r   <= '0;
      res_sh_r <= '0;
      carry_r  <= 1'b0;
      idx_r    <= '0;
      sum_r    <= '0;
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            // Subtract is A + ~B + 1; the +1 rides in on the carry register
            a_sh_r  <= bus.a;
            b_sh_r  <= bus.sub ? ~bus.b : bus.b;
            carry_r <= bus.sub ? 1'b1 : bus.cin;
            idx_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          a_sh_r   <= {16'h0000, a_sh_r[W-1:16]};
          b_sh_r   <= {16'h0000, b_sh_r[W-1:16]};
          res_sh_r <= res_next_s;
          carry_r  <= slice_s[16];
          idx_r    <= idx_r + IDX_W'(1);
          if (idx_r == LAST_IDX) begin
            // The top word of each operand sits in the low slot right now
            sum_r   <= res_next_s;
            cout_r  <= slice_s[16];
            ovf_r   <= (a_sh_r[15] == b_sh_r[15]) && (slice_s[15] != a_sh_r[15]);
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= RUN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.sum      = sum_r;
  assign bus.cout     = cout_r;
  assign bus.overflow = ovf_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
endmodule

// File: tb/tb_multiword_adder_ctrl.sv
// Randomised and directed checks of the multi-word adder sequencer against
// a full-width arithmetic reference model.
module tb_multiword_adder_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  multiword_adder_ctrl_if #(.NUM_WORDS(4)) bus4 ();
  multiword_adder_ctrl_if #(.NUM_WORDS(2)) bus2 ();

  multiword_adder_ctrl #(.NUM_WORDS(4)) dut4 (.clk(clk), .rst_n(rst_n),  .bus(bus4));
  multiword_adder_ctrl #(.NUM_WORDS(2)) dut2 (.clk(clk), .rst_n(rst2_n), .bus(bus2));

  // Reference: plain 64-bit integer arithmetic, signed range check for overflow
  function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                input logic sub, input logic cin,
                                output logic [63:0] s, output logic c, output logic o);
    logic [64:0]        u;
    logic signed [64:0] ext;
    if (sub) begin
      u   = {1'b0, a} - {1'b0, b};
      c   = (a >= b);
      ext = $signed({a[63], a}) - $signed({b[63], b});
    end else begin
      u   = {1'b0, a} + {1'b0, b} + {64'd0, cin};
      c   = u[64];
      ext = $signed({a[63], a}) + $signed({b[63], b}) + $signed({64'd0, cin});
    end
    s = u[63:0];
    o = ext[64] ^ ext[63];
  endfunction

  // Drive one operation on the 4-word unit and report what it did
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic sub,
                       input logic cin, input bit noise,
                       output logic [63:0] rs, output logic rc, output logic ro,
                       output int lat, output int busy_cnt, output bit changed,
                       output logic done_after);
    logic [63:0] prev_s;
    logic        prev_c;
    logic        prev_o;
    @(negedge clk);
    bus4.a = a; bus4.b = b; bus4.sub = sub; bus4.cin = cin; bus4.start = 1'b1;
    prev_s = bus4.sum; prev_c = bus4.cout; prev_o = bus4.overflow;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    lat = 0; busy_cnt = 0; changed = 1'b0;
    while (bus4.done !== 1'b1 && lat < 20) begin
      if (bus4.busy === 1'b1) busy_cnt++;
      if (bus4.sum !== prev_s || bus4.cout !== prev_c || bus4.overflow !== prev_o) changed = 1'b1;
      @(negedge clk);
      if (noise) begin
        bus4.a     = {$urandom, $urandom};
        bus4.b     = {$urandom, $urandom};
        bus4.sub   = 1'($urandom);
        bus4.cin   = 1'($urandom);
        bus4.start = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    bus4.start = 1'b0;
    rs = bus4.sum; rc = bus4.cout; ro = bus4.overflow;
    @(posedge clk); #1;
    done_after = bus4.done;
  endtask

  // Drive one operation on the 2-word unit
  task automatic op2(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic cin,
                     output logic [31:0] rs, output logic rc, output logic ro, output int lat);
    @(negedge clk);
    bus2.a = a; bus2.b = b; bus2.sub = sub; bus2.cin = cin; bus2.start = 1'b1;
    @(posedge clk); #1;
    bus2.start = 1'b0;
    lat = 0;
    while (bus2.done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rs = bus2.sum; rc = bus2.cout; ro = bus2.overflow;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst2_n = 1'b0;
    bus4.start = 1'b0; bus4.sub = 1'b0; bus4.cin = 1'b0; bus4.a = '0; bus4.b = '0;
    bus2.start = 1'b0; bus2.sub = 1'b0; bus2.cin = 1'b0; bus2.a = '0; bus2.b = '0;
    #1;
    for (int pass = 0; pass < 2; pass++) begin
      checks++; if (bus4.sum !== 64'd0) begin failures++; $display("FAIL reset_sum pass%0d: got %h want 0", pass, bus4.sum); end
      checks++; if (bus4.cout !== 1'b0) begin failures++; $display("FAIL reset_cout pass%0d: got %b want 0", pass, bus4.cout); end
      checks++; if (bus4.overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf pass%0d: got %b want 0", pass, bus4.overflow); end
      checks++; if (bus4.busy !== 1'b0) begin failures++; $display("FAIL reset_busy pass%0d: got %b want 0", pass, bus4.busy); end
      checks++; if (bus4.done !== 1'b0) begin failures++; $display("FAIL reset_done pass%0d: got %b want 0", pass, bus4.done); end
      checks++; if (bus2.sum !== 32'd0) begin failures++; $display("FAIL reset_sum2 pass%0d: got %h want 0", pass, bus2.sum); end
      if (pass == 0) begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1; rst2_n = 1'b1;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_directed();
    logic [63:0] ta [5] = '{64'h0000_0000_0000_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                            64'h8000_0000_0000_0000, 64'd5};
    logic [63:0] tb [5] = '{64'd1, 64'd0, 64'd1, 64'd1, 64'd7};
    logic        tsub [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        tcin [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [63:0] es [5] = '{64'h0000_0000_0001_0000, 64'd0, 64'h8000_0000_0000_0000,
                            64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
    logic        ec [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        eo [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [63:0] rs;
    logic        rc, ro, da;
    int          lat, bc;
    bit          chg;
    for (int i = 0; i < 5; i++) begin
      do_op(ta[i], tb[i], tsub[i], tcin[i], 1'b0, rs, rc, ro, lat, bc, chg, da);
      checks++; if (rs !== es[i]) begin failures++; $display("FAIL dir%0d_sum: got %h want %h", i, rs, es[i]); end
      checks++; if (rc !== ec[i]) begin failures++; $display("FAIL dir%0d_cout: got %b want %b", i, rc, ec[i]); end
      checks++; if (ro !== eo[i]) begin failures++; $display("FAIL dir%0d_ovf: got %b want %b", i, ro, eo[i]); end
      checks++; if (lat != 4) begin failures++; $display("FAIL dir%0d_latency: got %0d want 4", i, lat); end
      checks++; if (bc != 4) begin failures++; $display("FAIL dir%0d_busy_cycles: got %0d want 4", i, bc); end
      checks++; if (chg) begin failures++; $display("FAIL dir%0d_result_held: got changed want held", i); end
      checks++; if (da !== 1'b0) begin failures++; $display("FAIL dir%0d_done_pulse: got %b want 0", i, da); end
    end
  endtask

  task automatic test_random();
    logic [63:0] a, b, rs, xs;
    logic        sub, cin, rc, ro, xc, xo, da;
    int          lat, bc;
    bit          chg;
    for (int i = 0; i < 25; i++) begin
      a = {$urandom, $urandom};
      b = (i % 5 == 0) ? a : {$urandom, $urandom};
      sub = 1'($urandom); cin = 1'($urandom);
      model(a, b, sub, cin, xs, xc, xo);
      do_op(a, b, sub, cin, 1'b1, rs, rc, ro, lat, bc, chg, da);
      checks++; if (rs !== xs) begin failures++; $display("FAIL rnd%0d_sum: got %h want %h", i, rs, xs); end
      checks++; if (rc !== xc) begin failures++; $display("FAIL rnd%0d_cout: got %b want %b", i, rc, xc); end
      checks++; if (ro !== xo) begin failures++; $display("FAIL rnd%0d_ovf: got %b want %b", i, ro, xo); end
      checks++; if (lat != 4 || bc != 4 || chg || da !== 1'b0) begin
        failures++; $display("FAIL rnd%0d_timing: got lat=%0d busy=%0d chg=%0d done_after=%b want 4/4/0/0", i, lat, bc, chg, da);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] oa [4], ob [4], xs;
    logic        osub [4], ocin [4], xc, xo;
    int          cyc, last, w;
    bit          seen;
    for (int k = 0; k < 4; k++) begin
      oa[k] = {$urandom, $urandom}; ob[k] = {$urandom, $urandom};
      osub[k] = 1'($urandom); ocin[k] = 1'($urandom);
    end
    @(negedge clk);
    bus4.a = oa[0]; bus4.b = ob[0]; bus4.sub = osub[0]; bus4.cin = ocin[0]; bus4.start = 1'b1;
    cyc = 0; last = 0;
    for (int k = 0; k < 4; k++) begin
      seen = 1'b0; w = 0;
      while (!seen && w < 20) begin
        @(posedge clk); #1;
        cyc++; w++;
        if (bus4.done === 1'b1) seen = 1'b1;
      end
      model(oa[k], ob[k], osub[k], ocin[k], xs, xc, xo);
      checks++; if (!seen) begin failures++; $display("FAIL b2b%0d_done: got none want pulse", k); end
      checks++; if ((cyc - last) != 5) begin failures++; $display("FAIL b2b%0d_period: got %0d want 5", k, cyc - last); end
      checks++; if (bus4.sum !== xs || bus4.cout !== xc || bus4.overflow !== xo) begin
        failures++; $display("FAIL b2b%0d_result: got %h/%b/%b want %h/%b/%b", k, bus4.sum, bus4.cout, bus4.overflow, xs, xc, xo);
      end
      checks++; if (bus4.busy !== 1'b0) begin failures++; $display("FAIL b2b%0d_busy_in_done: got %b want 0", k, bus4.busy); end
      last = cyc;
      if (k < 3) begin
        bus4.a = oa[k+1]; bus4.b = ob[k+1]; bus4.sub = osub[k+1]; bus4.cin = ocin[k+1];
      end else begin
        bus4.start = 1'b0;
      end
    end
    @(posedge clk); #1;
    checks++; if (bus4.done !== 1'b0) begin failures++; $display("FAIL b2b_tail_done: got %b want 0", bus4.done); end
  endtask

  task automatic test_reset_abort();
    logic [63:0] rs;
    logic        rc, ro, da;
    int          lat, bc;
    bit          chg, dseen;
    do_op(64'h1234_5678_9ABC_DEF0, 64'd1, 1'b0, 1'b1, 1'b0, rs, rc, ro, lat, bc, chg, da);
    checks++; if (rs !== 64'h1234_5678_9ABC_DEF2) begin failures++; $display("FAIL abort_setup_sum: got %h want 123456789abcdef2", rs); end
    @(negedge clk);
    bus4.a = 64'h0000_0000_0000_FFFF; bus4.b = 64'd1; bus4.sub = 1'b0; bus4.cin = 1'b0; bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus4.busy !== 1'b0 || bus4.done !== 1'b0) begin
      failures++; $display("FAIL abort_flags: got busy=%b done=%b want 0/0", bus4.busy, bus4.done);
    end
    checks++; if (bus4.sum !== 64'd0 || bus4.cout !== 1'b0) begin
      failures++; $display("FAIL abort_result: got %h/%b want 0/0", bus4.sum, bus4.cout);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dseen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus4.done !== 1'b0 || bus4.busy !== 1'b0) dseen = 1'b1;
    end
    checks++; if (dseen) begin failures++; $display("FAIL abort_no_done: got activity want none"); end
    do_op(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 1'b0, rs, rc, ro, lat, bc, chg, da);
    checks++; if (rs !== 64'h0000_0000_0001_0000 || rc !== 1'b0 || ro !== 1'b0) begin
      failures++; $display("FAIL abort_rerun_result: got %h/%b/%b want 0000000000010000/0/0", rs, rc, ro);
    end
    checks++; if (lat != 4) begin failures++; $display("FAIL abort_rerun_latency: got %0d want 4", lat); end
  endtask

  task automatic test_two_words();
    logic [31:0] rs;
    logic        rc, ro;
    int          lat;
    op2(32'h0000_1234, 32'd1, 1'b0, 1'b0, rs, rc, ro, lat);
    checks++; if (rs !== 32'h0000_1235) begin failures++; $display("FAIL w2_setup_sum: got %h want 00001235", rs); end
    @(negedge clk);
    bus2.a = 32'hFFFF_FFFF; bus2.b = 32'd1; bus2.sub = 1'b0; bus2.cin = 1'b0; bus2.start = 1'b1;
    @(posedge clk); #1;
    bus2.start = 1'b0;
    checks++; if (bus2.busy !== 1'b1) begin failures++; $display("FAIL w2_busy: got %b want 1", bus2.busy); end
    rst2_n = 1'b0;
    #1;
    checks++; if (bus2.busy !== 1'b0 || bus2.done !== 1'b0 || bus2.sum !== 32'd0 || bus2.cout !== 1'b0) begin
      failures++; $display("FAIL w2_abort: got busy=%b done=%b sum=%h cout=%b want 0/0/0/0", bus2.busy, bus2.done, bus2.sum, bus2.cout);
    end
    repeat (2) @(negedge clk);
    rst2_n = 1'b1;
    op2(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, rs, rc, ro, lat);
    checks++; if (rs !== 32'd0 || rc !== 1'b1 || ro !== 1'b0) begin
      failures++; $display("FAIL w2_result: got %h/%b/%b want 00000000/1/0", rs, rc, ro);
    end
    checks++; if (lat != 2) begin failures++; $display("FAIL w2_latency: got %0d want 2", lat); end
    op2(32'h8000_0000, 32'd1, 1'b1, 1'b0, rs, rc, ro, lat);
    checks++; if (rs !== 32'h7FFF_FFFF || rc !== 1'b1 || ro !== 1'b1) begin
      failures++; $display("FAIL w2_sub: got %h/%b/%b want 7fffffff/1/1", rs, rc, ro);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_abort();
    test_two_words();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multiword_adder_ctrl.md
Name: multiword_adder_ctrl

Overview:
Sequencer that performs wide (16*NUM_WORDS-bit) add/subtract by time-multiplexing one internal 16-bit add slice, one word per clock, least-significant word first. The carry is held in a register between slices. Operands are captured on Start, and results are presented atomically with a one-cycle Done pulse. It serves as the multi-precision arithmetic engine next to the existing 16-bit adders in the datapath labs.

Parameters:
NUM_WORDS, 4, number of 16-bit words per operand; legal range 2..8; default gives a 64-bit operation.

Ports:
Clk  input  1  system clock, rising edge
Reset_n  input  1  asynchronous active-low reset
Start  input  1  request; sampled only when not Busy
Sub  input  1  0 = A+B+Cin, 1 = A-B; captured with Start
Cin  input  1  carry-in for add mode; ignored when Sub=1
A  input  16*NUM_WORDS  operand A; captured with Start
B  input  16*NUM_WORDS  operand B; captured with Start
Sum  output  16*NUM_WORDS  registered result; holds last result
Cout  output  1  carry out of MSB word; in subtract mode, 1 = no borrow
Overflow  output  1  signed two's-complement overflow of the full-width result
Busy  output  1  high while words are being processed
Done  output  1  one-cycle pulse when Sum/Cout/Overflow update

Behaviour:
- Reset (Reset_n=0, asynchronous): state IDLE; Sum=0, Cout=0, Overflow=0, Busy=0, Done=0; word index=0; carry register=0; operand shift registers=0.
- Reset asserted mid-operation: abort immediately, with no Done and no partial Sum update. After release the block is IDLE and accepts Start on the first edge.
- FSM states: IDLE, RUN, DONE.
  - IDLE: Start=1 at edge E0 -> RUN. At that edge, capture A into a_sh and B into b_sh (B is inverted when Sub=1). Carry register loads Sub ? 1 : Cin. Index loads 0.
  - RUN: each edge computes {c, s} = a_sh[15:0] + b_sh[15:0] + carry (17-bit result).
    - s is shifted into the top of a result shift register.
    - a_sh and b_sh shift right by 16.
    - carry <= c; index increments.
  - RUN, final word (index == NUM_WORDS-1) at edge E_NUM_WORDS:
    - Sum <= the full result, including the final s.
    - Cout <= c.
    - Overflow <= (a_msb == b_eff_msb) && (s[15] != a_msb), where b_eff is B after inversion.
    - Next state DONE.
  - DONE: Done=1 and Busy=0 for exactly one cycle. Start=1 in DONE is accepted exactly as in IDLE (back-to-back operation) and goes to RUN; otherwise -> IDLE.
- Busy=1 exactly in RUN (NUM_WORDS cycles). Done=1 exactly in DONE.
- Start while Busy is ignored, not queued. Input changes during RUN have no effect.
- Latency: Done is high in the cycle following edge E0+NUM_WORDS (NUM_WORDS edges after acceptance). Throughput is one operation per NUM_WORDS+1 cycles.
- Sum, Cout and Overflow change only at the final RUN edge or on reset, never mid-operation. They are stable and hold indefinitely between operations.
- Arithmetic is modulo 2^(16*NUM_WORDS). Carry propagates only through the carry register between words, never combinationally across words.
- The carry register is internal: it is not cleared in IDLE and is reloaded only at Start.

Test Plan:
NUM_WORDS=4 unless noted.
1. A=0x0000_0000_0000_FFFF, B=1, Sub=0, Cin=0, Start pulse -> Busy high for 4 cycles; Done pulse in cycle 5 after Start edge; Sum=0x0000_0000_0001_0000, Cout=0, Overflow=0.
2. A=0xFFFF_FFFF_FFFF_FFFF, B=0, Cin=1 -> Sum=0, Cout=1, Overflow=0. Check that Sum holds its old value during Busy.
3. A=0x7FFF_FFFF_FFFF_FFFF, B=1, Sub=0 -> Sum=0x8000_0000_0000_0000, Overflow=1, Cout=0. Then Sub=1, A=0x8000_0000_0000_0000, B=1 -> Sum=0x7FFF_FFFF_FFFF_FFFF, Overflow=1, Cout=1.
4. Sub=1, A=5, B=7, Cin=1 (Cin ignored) -> Sum=0xFFFF_FFFF_FFFF_FFFE, Cout=0, Overflow=0.
5. Start held high continuously with new operands applied each DONE cycle -> a Done pulse every 5 cycles. Start pulses during RUN change nothing, and no extra Done occurs.
6. Reset_n low at the 2nd RUN cycle -> Busy, Done, Sum and Cout are 0 immediately, with no Done afterwards. After release, the scenario-1 operation completes with the scenario-1 results. Repeat with NUM_WORDS=2: A=0xFFFF_FFFF, B=1 -> Sum=0, Cout=1, with Done 2 edges after Start.
